rr_lock_arbiter: RTL and testbench

RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_lock_arbiter.sv | 148 ++++++++++++++
 tb/tb_rr_lock_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin lock arbiter: requester count,
// default hold limit and the FSM state encoding.
package arb_pkg;

  localparam int ARB_N        = 4;
  localparam int ARB_MAX_HOLD = 8;

  // IDLE: nothing granted. BUSY: exactly one requester owns the resource.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker. It searches req starting at index
// 'start' and wrapping modulo N, skipping bits set in 'mask'. It returns
// the first eligible index in idx and raises found when one exists.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk the N candidates in rotated order and keep only the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = start;
    for (int i = 0; i < N; i++) begin
      cand = start + IW'(i);
      if (!found && req[cand] && !mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a locked grant and a hold-time limit.
//
// Request/grant protocol: a requester holds its req bit high for as long
// as it wants the resource. A grant, once issued, stays locked to its
// owner until the owner drops req (release) or has held the grant for
// MAX_HOLD cycles (timeout). Other req bits are ignored while a grant is
// locked. On release or timeout the next owner is chosen at the same
// edge, so hand-over is back-to-back. The timeout output pulses for the
// first cycle of the changed grant.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input  logic                 c,
  input  logic                 r,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 timeout,
  output logic                 state_dbg
);

  localparam int IW  = $clog2(N);
  localparam int HCW = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
  localparam logic [IW-1:0]  PTR_RST   = IW'(N - 1);

  arb_state_e     state, state_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [HCW-1:0] hold_cnt, hold_n;
  logic [N-1:0]   gnt_n;
  logic [IW-1:0]  gnt_id_n;
  logic           gnt_valid_n;
  logic           timeout_n;

  logic [N-1:0]   pick_mask;
  logic [IW-1:0]  pick_start;
  logic           pick_found;
  logic [IW-1:0]  pick_idx;

  logic           owner_req;
  logic           at_limit;

  // The search always begins just after the last granted index. While a
  // grant is held the owner is masked so a timed-out owner cannot re-win
  // at the same edge; in IDLE every request is eligible.
  assign pick_start = ptr + IW'(1);
  assign pick_mask  = (state == BUSY) ? gnt : '0;
  assign owner_req  = req[ptr];
  assign at_limit   = (hold_cnt == HOLD_LAST);
  assign state_dbg  = state;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state logic: grant from IDLE, hold/count in BUSY, and re-arbitrate
  // or fall back to IDLE on release or timeout.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    hold_n      = hold_cnt;
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    gnt_valid_n = gnt_valid;
    timeout_n   = 1'b0;

    case (state)
      IDLE: begin
        if (pick_found) begin
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          gnt_id_n        = pick_idx;
          gnt_valid_n     = 1'b1;
          ptr_n           = pick_idx;
          hold_n          = '0;
          state_n         = BUSY;
        end
      end

      BUSY: begin
        if (owner_req && !at_limit) begin
          // Owner keeps the grant; hold_cnt saturates at HOLD_LAST via the
          // timeout path, so it never wraps.
          hold_n = hold_cnt + HCW'(1);
        end else begin
          // Release (owner dropped req) or timeout (owner still asking).
          timeout_n = owner_req;
          hold_n    = '0;
          if (pick_found) begin
            gnt_n           = '0;
            gnt_n[pick_idx] = 1'b1;
            gnt_id_n        = pick_idx;
            gnt_valid_n     = 1'b1;
            ptr_n           = pick_idx;
            state_n         = BUSY;
          end else begin
            gnt_n       = '0;
            gnt_id_n    = '0;
            gnt_valid_n = 1'b0;
            state_n     = IDLE;
          end
        end
      end

      default: begin
        gnt_n       = '0;
        gnt_id_n    = '0;
        gnt_valid_n = 1'b0;
        hold_n      = '0;
        state_n     = IDLE;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs; reset clears the
  // grant immediately without waiting for a clock edge.
  always_ff @(posedge c or negedge r) begin
    if (!r) begin
      state     <= IDLE;
      ptr       <= PTR_RST;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      hold_cnt  <= hold_n;
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      gnt_valid <= gnt_valid_n;
      timeout   <= timeout_n;
    end
  end

endmodule : rr_lock_arbiter

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter (N=4, MAX_HOLD=8). Expected grants
// are hand-computed from the round-robin and hold-limit rules.
module tb_rr_lock_arbiter;

  logic       c;
  logic       r;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;

  rr_lock_arbiter #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .c         (c),
    .r         (r),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .state_dbg (state_dbg)
  );

  // Clock: posedges at 5, 15, 25, ...
  initial c = 1'b0;
  always #5 c = ~c;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  // Check the full output set against one expected grant.
  task automatic check_gnt(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
    logic [1:0] exp_id;
    exp_id = 2'd0;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) exp_id = 2'(i);
    check({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ".valid"}, 32'(gnt_valid), 32'(exp_gnt != 4'b0000));
    if (exp_gnt != 4'b0000) check({tag, ".id"}, 32'(gnt_id), 32'(exp_id));
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  // n further edges with the grant expected to stay put and no timeout.
  task automatic hold_for(input string tag, input logic [3:0] exp_gnt, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      check_gnt(tag, exp_gnt, 1'b0);
    end
  endtask

  task automatic do_reset();
    r = 1'b0;
    tick();
    r = 1'b1;
  endtask

  initial begin
    r   = 1'b0;
    req = 4'b0000;

    // Reset values while r is low.
    #12;
    check_gnt("rst", 4'b0000, 1'b0);
    check("rst.id", 32'(gnt_id), 32'd0);
    check("rst.state", 32'(state_dbg), 32'd0);
    tick();
    r = 1'b1;

    // Basic grant, non-owner churn ignored, release hands over.
    req = 4'b1101;
    tick();
    check_gnt("t1.first", 4'b0001, 1'b0);
    check("t1.state", 32'(state_dbg), 32'd1);
    req = 4'b0011;
    tick();
    check_gnt("t1.lock", 4'b0001, 1'b0);
    req = 4'b1100;
    tick();
    check_gnt("t1.handover", 4'b0100, 1'b0);
    req = 4'b0000;
    tick();
    check_gnt("t1.idle", 4'b0000, 1'b0);
    check("t1.idle_state", 32'(state_dbg), 32'd0);

    // Rotation 0,1,2,3 with each owner dropping after two cycles.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_gnt("t2.grant", 4'(1 << k), 1'b0);
      tick();
      check_gnt("t2.hold", 4'(1 << k), 1'b0);
      req[k] = 1'b0;
    end
    tick();
    check_gnt("t2.end", 4'b0000, 1'b0);

    // Single requester times out, idles a cycle, then wins again.
    req = 4'b0010;
    tick();
    check_gnt("t3.grant", 4'b0010, 1'b0);
    hold_for("t3.hold", 4'b0010, 7);
    tick();
    check_gnt("t3.timeout", 4'b0000, 1'b1);
    check("t3.to_state", 32'(state_dbg), 32'd0);
    tick();
    check_gnt("t3.regrant", 4'b0010, 1'b0);
    req = 4'b0000;
    tick();
    check_gnt("t3.end", 4'b0000, 1'b0);

    // Two requesters trade on timeout with no idle gap. ptr is 1 here,
    // so the search order is 2,3,0,1 and requester 0 wins first.
    req = 4'b0011;
    tick();
    check_gnt("t4.grant0", 4'b0001, 1'b0);
    hold_for("t4.hold0", 4'b0001, 7);
    tick();
    check_gnt("t4.to0", 4'b0010, 1'b1);
    hold_for("t4.hold1", 4'b0010, 7);
    tick();
    check_gnt("t4.to1", 4'b0001, 1'b1);
    tick();
    check_gnt("t4.after", 4'b0001, 1'b0);
    req = 4'b0000;
    tick();
    check_gnt("t4.end", 4'b0000, 1'b0);

    // Asynchronous reset mid-grant. ptr is 0, so requester 3 wins.
    req = 4'b1000;
    tick();
    check_gnt("t5.grant", 4'b1000, 1'b0);
    #2;
    r = 1'b0;
    #1;
    check_gnt("t5.async", 4'b0000, 1'b0);
    tick();
    check_gnt("t5.held", 4'b0000, 1'b0);
    r   = 1'b1;
    req = 4'b1001;
    tick();
    check_gnt("t5.resume", 4'b0001, 1'b0);

    // No requests at all: everything stays quiet.
    do_reset();
    req = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_gnt("t6.quiet", 4'b0000, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_rr_lock_arbiter
